// File: rtl/upb_tcam_writer_if.sv
// upb_tcam_writer_if: request handshake and TCAM write bus of upb_tcam_writer.
interface upb_tcam_writer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [9:0]            req_index;
    logic [127:0]          req_key;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  wen;
    logic [31:0]           waddr;
    logic [31:0]           wdata;
    logic                  done;
    logic                  err;
    modport master (
        output req_valid, req_op, req_index, req_key, req_data,
        input  req_ready, wen, waddr, wdata, done, err
    );
    modport slave (
        input  req_valid, req_op, req_index, req_key, req_data,
        output req_ready, wen, waddr, wdata, done, err
    );
endinterface

// File: rtl/upb_tcam_writer.sv
// upb_tcam_writer: turns INSTALL/REMOVE/CLEAR_ALL requests into TCAM register writes.
// Define UPB_TCAM_WRITER_SAFE_UPDATE_EN to deactivate an entry before rewriting its key.
module upb_tcam_writer #(
    parameter int TCAM_DEPTH = 64,
    parameter int DATA_WIDTH = 16,
    parameter int WRITE_GAP  = 0
) (
    input logic              clk_i,
    input logic              rst_n_i,
    upb_tcam_writer_if.slave bus_if
);
    localparam int NW = (TCAM_DEPTH + 31) / 32;
    localparam int SW = NW * 32;
    localparam int IW = $clog2(SW);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DEACT = 3'd1;
    localparam logic [2:0] KEY   = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] ACT   = 3'd4;
    localparam logic [2:0] CLR   = 3'd5;
    localparam logic [2:0] GAP   = 3'd6;
    localparam logic [2:0] FIN   = 3'd7;
`ifdef UPB_TCAM_WRITER_SAFE_UPDATE_EN
    localparam logic [2:0] INS_FIRST = DEACT;
`else
    localparam logic [2:0] INS_FIRST = KEY;
`endif

    logic [2:0]            state_q, state_d, nx_q, nx_d, seq;
    logic [4:0]            wc_q, wc_d, seq_wc, ws;
    logic [3:0]            gc_q, gc_d;
    logic [SW-1:0]         sh_q, sh_d;
    logic                  rej_q, rej_d, adv;
    logic [1:0]            op_q, op_d;
    logic [9:0]            idx_q, idx_d;
    logic [127:0]          key_q, key_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wen_q, wen_d;
    logic [31:0]           waddr_q, waddr_d, wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        nx_d    = nx_q;
        wc_d    = wc_q;
        gc_d    = gc_q;
        sh_d    = sh_q;
        rej_d   = rej_q;
        op_d    = op_q;
        idx_d   = idx_q;
        key_d   = key_q;
        data_d  = data_q;
        adv     = 1'b0;
        seq     = IDLE;
        seq_wc  = wc_q;
        case (state_q)
            IDLE: if (bus_if.req_valid) begin
                op_d    = bus_if.req_op;
                idx_d   = bus_if.req_index;
                key_d   = bus_if.req_key;
                data_d  = bus_if.req_data;
                wc_d    = '0;
                rej_d   = bus_if.req_op == 2'd3 ||
                          (bus_if.req_op != 2'd2 && {1'b0, bus_if.req_index} >= 11'(TCAM_DEPTH));
                state_d = rej_d ? FIN : bus_if.req_op == 2'd2 ? CLR :
                          bus_if.req_op == 2'd1 ? ACT : INS_FIRST;
            end
            DEACT: begin
                adv    = 1'b1;
                seq    = KEY;
                seq_wc = '0;
            end
            KEY: begin
                adv    = 1'b1;
                seq    = wc_q[1:0] == 2'd3 ? DATA : KEY;
                seq_wc = wc_q + 5'd1;
            end
            DATA: begin
                adv = 1'b1;
                seq = ACT;
            end
            ACT: state_d = FIN;
            CLR: if (wc_q == 5'(NW - 1)) state_d = FIN;
            else begin
                adv    = 1'b1;
                seq    = CLR;
                seq_wc = wc_q + 5'd1;
            end
            GAP: if (gc_q == 4'd0) state_d = nx_q;
            else gc_d = gc_q - 4'd1;
            FIN: begin
                state_d = IDLE;
                rej_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Between writes the next write state is parked in nx_q while GAP counts down.
        if (adv) begin
            wc_d = seq_wc;
            if (WRITE_GAP > 0) begin
                state_d = GAP;
                nx_d    = seq;
                gc_d    = 4'(WRITE_GAP - 1);
            end else state_d = seq;
        end
        if (state_d == DEACT || (state_d == ACT && state_q != ACT)) sh_d[idx_d[IW-1:0]] = state_d == ACT && op_d == 2'd0;
        if (state_d == CLR) sh_d = '0;
        wen_d   = state_d inside {DEACT, KEY, DATA, ACT, CLR};
        ws      = state_d == CLR ? wc_d : idx_d[9:5];
        waddr_d = !wen_d ? '0 :
                  state_d == KEY  ? 32'h1000 + {20'd0, idx_d, 2'd0} + {30'd0, wc_d[1:0]} :
                  state_d == DATA ? 32'h2000 + {22'd0, idx_d} : 32'h3000 + {27'd0, ws};
        wdata_d = !wen_d ? '0 :
                  state_d == KEY  ? key_d[32*wc_d[1:0] +: 32] :
                  state_d == DATA ? 32'(data_d) : sh_d[32*ws +: 32];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            nx_q    <= IDLE;
            wc_q    <= '0;
            gc_q    <= '0;
            sh_q    <= '0;
            rej_q   <= 1'b0;
            op_q    <= '0;
            idx_q   <= '0;
            key_q   <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            nx_q    <= nx_d;
            wc_q    <= wc_d;
            gc_q    <= gc_d;
            sh_q    <= sh_d;
            rej_q   <= rej_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus_if.req_ready = rst_n_i && state_q == IDLE;
    assign bus_if.wen       = wen_q;
    assign bus_if.waddr     = waddr_q;
    assign bus_if.wdata     = wdata_q;
    assign bus_if.done      = state_q == FIN && !rej_q;
    assign bus_if.err       = state_q == FIN && rej_q;
endmodule

// File: tb/tb_upb_tcam_writer.sv
// tb_upb_tcam_writer: randomized request bench for two upb_tcam_writer configurations
// (64 entries / no gap, 40 entries / gap 2) against a write-list reference model.
module tb_upb_tcam_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         sel = 1'b0;
    logic         v = 1'b0;
    logic [1:0]   op = '0;
    logic [9:0]   idx = '0;
    logic [127:0] key = '0;
    logic [15:0]  data = '0;
    logic         ready, wen, done, err;
    logic [31:0]  waddr, wdata;

    upb_tcam_writer_if #(.DATA_WIDTH(16)) if0 ();
    upb_tcam_writer_if #(.DATA_WIDTH(16)) if1 ();

    assign if0.req_valid = v && !sel;
    assign if1.req_valid = v && sel;
    assign if0.req_op    = op;
    assign if1.req_op    = op;
    assign if0.req_index = idx;
    assign if1.req_index = idx;
    assign if0.req_key   = key;
    assign if1.req_key   = key;
    assign if0.req_data  = data;
    assign if1.req_data  = data;
    assign ready = sel ? if1.req_ready : if0.req_ready;
    assign wen   = sel ? if1.wen : if0.wen;
    assign waddr = sel ? if1.waddr : if0.waddr;
    assign wdata = sel ? if1.wdata : if0.wdata;
    assign done  = sel ? if1.done : if0.done;
    assign err   = sel ? if1.err : if0.err;

    upb_tcam_writer #(.TCAM_DEPTH(64), .DATA_WIDTH(16), .WRITE_GAP(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .bus_if(if0));
    upb_tcam_writer #(.TCAM_DEPTH(40), .DATA_WIDTH(16), .WRITE_GAP(2)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .bus_if(if1));

`ifdef UPB_TCAM_WRITER_SAFE_UPDATE_EN
    localparam bit SAFE = 1'b1;
`else
    localparam bit SAFE = 1'b0;
`endif

    int          checks = 0, passed = 0;
    int          dep[2] = '{64, 40};
    int          gp[2] = '{0, 2};
    bit [1023:0] msh[2];
    logic [31:0] ea[$], ed[$];

    // Reference: the list of (address, data) writes a request must produce.
    task automatic predict(input int s, input logic [1:0] o, input int i, input logic [127:0] k,
                           input logic [15:0] d, output bit rej);
        ea.delete();
        ed.delete();
        rej = o == 3 || (o < 2 && i >= dep[s]);
        if (rej) return;
        if (o == 0) begin
            if (SAFE) begin
                msh[s][i] = 1'b0;
                ea.push_back(32'h3000 + i / 32);
                ed.push_back(msh[s][32*(i/32) +: 32]);
            end
            for (int w = 0; w < 4; w++) begin
                ea.push_back(32'h1000 + 4 * i + w);
                ed.push_back(k[32*w +: 32]);
            end
            ea.push_back(32'h2000 + i);
            ed.push_back({16'd0, d});
            msh[s][i] = 1'b1;
            ea.push_back(32'h3000 + i / 32);
            ed.push_back(msh[s][32*(i/32) +: 32]);
        end else if (o == 1) begin
            msh[s][i] = 1'b0;
            ea.push_back(32'h3000 + i / 32);
            ed.push_back(msh[s][32*(i/32) +: 32]);
        end else begin
            for (int w = 0; w < (dep[s] + 31) / 32; w++) begin
                ea.push_back(32'h3000 + w);
                ed.push_back(32'd0);
            end
            msh[s] = '0;
        end
    endtask

    task automatic run_req(input int s, input logic [1:0] o, input int i, input logic [127:0] k,
                           input logic [15:0] d, input string nm);
        bit rej;
        int nw, donec, readyc, kk, dn, dc, ec, en, rc, idle_bad;
        predict(s, o, i, k, d, rej);
        nw = ea.size();
        @(negedge clk);
        sel = s[0];
        op = o;
        idx = 10'(i);
        key = k;
        data = d;
        v = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) $display("FAIL %s ready_before: got %b want 1", nm, ready);
        else passed++;
        @(posedge clk);
        #1;
        v = 1'b0;
        op = 2'($urandom);
        idx = 10'($urandom);
        key = {$urandom, $urandom, $urandom, $urandom};
        data = 16'($urandom);
        donec = rej ? -1 : 2 + (nw - 1) * (gp[s] + 1);
        readyc = rej ? 2 : donec + 1;
        kk = 0; dn = 0; dc = -1; en = 0; ec = -1; rc = -1; idle_bad = 0;
        for (int c = 1; c <= readyc; c++) begin
            @(negedge clk);
            if (wen === 1'b1) begin
                checks++;
                if (kk < nw && waddr === ea[kk] && wdata === ed[kk] && c == 1 + kk * (gp[s] + 1)) passed++;
                else $display("FAIL %s write%0d: cycle %0d addr %h data %h, want cycle %0d addr %h data %h",
                              nm, kk, c, waddr, wdata, 1 + kk * (gp[s] + 1),
                              kk < nw ? ea[kk] : 32'hx, kk < nw ? ed[kk] : 32'hx);
                kk++;
            end else if (waddr !== 32'd0 || wdata !== 32'd0) idle_bad++;
            if (done === 1'b1) begin dn++; dc = c; end
            if (err === 1'b1) begin en++; ec = c; end
            if (ready === 1'b1 && rc < 0) rc = c;
        end
        checks++;
        if (kk != nw) $display("FAIL %s write_count: got %0d want %0d", nm, kk, nw);
        else passed++;
        checks++;
        if (dn != (rej ? 0 : 1) || dc != donec) $display("FAIL %s done: got %0d pulses last cycle %0d want %0d at %0d", nm, dn, dc, rej ? 0 : 1, donec);
        else passed++;
        checks++;
        if (en != (rej ? 1 : 0) || ec != (rej ? 1 : -1)) $display("FAIL %s err: got %0d pulses at %0d want %0d at %0d", nm, en, ec, rej ? 1 : 0, rej ? 1 : -1);
        else passed++;
        checks++;
        if (rc != readyc) $display("FAIL %s ready_return: got cycle %0d want %0d", nm, rc, readyc);
        else passed++;
        checks++;
        if (idle_bad != 0) $display("FAIL %s idle_bus: got %0d nonzero idle cycles want 0", nm, idle_bad);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if0.req_ready, if0.wen, if0.waddr, if0.wdata, if0.done, if0.err} !== '0)
            $display("FAIL reset_dut0: got rdy %b wen %b addr %h data %h done %b err %b want all 0",
                     if0.req_ready, if0.wen, if0.waddr, if0.wdata, if0.done, if0.err);
        else passed++;
        checks++;
        if ({if1.req_ready, if1.wen, if1.waddr, if1.wdata, if1.done, if1.err} !== '0)
            $display("FAIL reset_dut1: got rdy %b wen %b addr %h data %h done %b err %b want all 0",
                     if1.req_ready, if1.wen, if1.waddr, if1.wdata, if1.done, if1.err);
        else passed++;
        rst_n = 1'b1;
        msh[0] = '0;
        msh[1] = '0;
        @(negedge clk);
        checks++;
        if ({if0.req_ready, if1.req_ready} !== 2'b11) $display("FAIL reset_release_ready: got %b%b want 11", if0.req_ready, if1.req_ready);
        else passed++;
    endtask

    task automatic test_install();
        run_req(0, 2'd0, 5, 128'h44444444_33333333_22222222_11111111, 16'hBEEF, "install5");
    endtask

    task automatic test_remove();
        run_req(0, 2'd0, 1, {4{$urandom}}, 16'h0101, "install1");
        run_req(0, 2'd0, 33, {4{$urandom}}, 16'h3333, "install33");
        run_req(0, 2'd1, 33, {4{$urandom}}, 16'h0, "remove33");
    endtask

    task automatic test_gap();
        run_req(1, 2'd1, 3, {4{$urandom}}, 16'h0, "gap_remove3");
        run_req(1, 2'd0, 7, {4{$urandom}}, 16'h7777, "gap_install7");
        run_req(1, 2'd0, 7, {4{$urandom}}, 16'h8888, "gap_reinstall7");
    endtask

    task automatic test_reject();
        run_req(0, 2'd0, 64, {4{$urandom}}, 16'h1, "rej_install64");
        run_req(0, 2'd1, 1023, {4{$urandom}}, 16'h1, "rej_remove1023");
        run_req(1, 2'd0, 40, {4{$urandom}}, 16'h1, "rej_install40");
        run_req(0, 2'd3, 2, {4{$urandom}}, 16'h1, "rej_op3");
        run_req(0, 2'd1, 5, {4{$urandom}}, 16'h0, "remove5_after_rej");
    endtask

    task automatic test_clear_all();
        run_req(1, 2'd0, 3, {4{$urandom}}, 16'h0003, "clr_install3");
        run_req(1, 2'd0, 39, {4{$urandom}}, 16'h0027, "clr_install39");
        run_req(1, 2'd0, 35, {4{$urandom}}, 16'h0023, "clr_install35");
        run_req(1, 2'd2, int'($urandom_range(0, 1023)), {4{$urandom}}, 16'h0, "clear_all");
        run_req(1, 2'd1, 39, {4{$urandom}}, 16'h0, "clr_remove39");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int s;
            int r;
            s = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            run_req(s, r < 5 ? 2'd0 : r < 8 ? 2'd1 : r < 9 ? 2'd2 : 2'd3,
                    int'($urandom_range(0, dep[s] + 3)), {4{$urandom}}, 16'($urandom), "random");
        end
    endtask

    task automatic test_reset_abort();
        int c;
        int bad;
        run_req(0, 2'd0, 9, {4{$urandom}}, 16'h0009, "abort_pre_install9");
        @(negedge clk);
        sel = 1'b0;
        op = 2'd0;
        idx = 10'd12;
        key = {4{$urandom}};
        v = 1'b1;
        @(posedge clk);
        #1 v = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(wen === 1'b1 && waddr === 32'h1000 + 4 * 12 + 2) && c < 20);
        checks++;
        if (c >= 20) $display("FAIL abort_third_key: got no write to %h within 20 cycles", 32'h1000 + 4 * 12 + 2);
        else passed++;
        rst_n = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (wen !== 1'b0 || waddr !== 32'd0 || ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) $display("FAIL abort_reset_quiet: got %0d samples with activity want 0", bad);
        else passed++;
        rst_n = 1'b1;
        msh[0] = '0;
        msh[1] = '0;
        #1;
        checks++;
        if (ready !== 1'b1) $display("FAIL abort_ready_after_release: got %b want 1", ready);
        else passed++;
        run_req(0, 2'd1, 9, {4{$urandom}}, 16'h0, "abort_remove9");
        run_req(1, 2'd1, 7, {4{$urandom}}, 16'h0, "abort_remove7_dut1");
    endtask

    initial begin
        test_reset();
        test_install();
        test_remove();
        test_gap();
        test_reject();
        test_clear_all();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/upb_tcam_writer.md
UPB_TCAM_WRITER -- requirements
Module: upb_tcam_writer

Interface
REQ-001 Parameter TCAM_DEPTH, default 64: number of TCAM entries, 1..1024.
REQ-002 Parameter DATA_WIDTH, default 16: width of the data stored per entry, 1..32.
REQ-003 Parameter WRITE_GAP, default 0: idle cycles inserted between consecutive writes, 0..15.
REQ-004 CLK  in  1  sole clock; all logic on rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 req_op  in  2  request opcode: 0 INSTALL, 1 REMOVE, 2 CLEAR_ALL, 3 reserved (rejected).
REQ-009 req_index  in  10  target entry index.
REQ-010 req_key  in  128  key image; word k = req_key[32k+31:32k], k=0..3.
REQ-011 req_data  in  DATA_WIDTH  data stored behind the entry.
REQ-012 wen  out  1  TCAM write strobe.
REQ-013 waddr  out  32  TCAM write address.
REQ-014 wdata  out  32  TCAM write data.
REQ-015 done  out  1  one-cycle pulse on completion of an accepted request.
REQ-016 err  out  1  one-cycle pulse on rejection of a request.

Function
REQ-017 The block SHALL generate the TCAM write sequence: key word k at 0x1000+4*index+k, data at 0x2000+index, active word w at 0x3000+w.
REQ-018 wen, waddr and wdata SHALL be registered; when wen=0, waddr and wdata SHALL be 0.
REQ-019 req_ready SHALL be 1 only in state IDLE.
REQ-020 States: IDLE, DEACT, KEY, DATA, ACT, CLR, GAP, FIN; KEY uses a 2-bit word counter; CLR uses a word counter.
REQ-021 The block SHALL keep a TCAM_DEPTH-bit shadow of the active bits; each active-word write SHALL carry shadow bits [32w+31:32w] after the update, with bits >= TCAM_DEPTH written as 0.
REQ-022 INSTALL SHALL perform, in order: DEACT (clear bit index) if enabled, KEY words 0..3, DATA (req_data zero-extended to 32 bits), ACT (set bit index).
REQ-023 REMOVE SHALL perform a single ACT write with bit index cleared.
REQ-024 CLEAR_ALL SHALL write 0 to active words 0..ceil(TCAM_DEPTH/32)-1 in ascending order, then zero the shadow; req_index is ignored.
REQ-025 An INSTALL or REMOVE with req_index >= TCAM_DEPTH, or any opcode 3, SHALL be rejected: err pulses in the cycle after acceptance, no writes occur, and the block returns to IDLE.
REQ-026 The first write SHALL occur in the cycle after acceptance; each write SHALL last exactly one cycle; WRITE_GAP idle cycles SHALL separate consecutive writes, with no gap after the last write.
REQ-027 Request fields SHALL be latched at acceptance; input changes during a sequence SHALL have no effect.
REQ-028 done SHALL pulse in the cycle after the final write, with the state in FIN, and req_ready SHALL return to 1 in the following cycle.
REQ-029 INSTALL to an already-active index SHALL be legal and SHALL overwrite the entry; REMOVE of an inactive index SHALL still write.

Reset
REQ-030 While RST_N=0: req_ready=0, wen=0, waddr=0, wdata=0, done=0, err=0, shadow=0, state=IDLE.
REQ-031 Assertion of RST_N mid-sequence SHALL abort immediately with no further writes; req_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-032 Macro UPB_TCAM_WRITER_SAFE_UPDATE_EN: when defined, INSTALL SHALL include the DEACT write, so a partially written key is never matched (7 writes).
REQ-033 Without UPB_TCAM_WRITER_SAFE_UPDATE_EN, INSTALL SHALL omit DEACT (6 writes); all other behaviour SHALL be identical.

Verification
REQ-034 SAFE_UPDATE_EN, WRITE_GAP=0, INSTALL index 5, key 0x44..33..22..11, data 0xBEEF, accepted at cycle 0 -> wen in cycles 1..7, addresses 0x3000, 0x1014, 0x1015, 0x1016, 0x1017, 0x2005, 0x3000; final wdata=0x00000020; done at cycle 8.
REQ-035 INSTALL of index 33, then REMOVE of index 33, TCAM_DEPTH=64 -> final write of the REMOVE: waddr=0x3001, wdata=0x00000000; INSTALL of index 1 beforehand leaves word 0 = 0x00000002 unaffected.
REQ-036 WRITE_GAP=2, REMOVE then INSTALL without SAFE_UPDATE_EN -> consecutive wen pulses exactly 3 cycles apart; 6 writes total for the INSTALL.
REQ-037 INSTALL with index 64, TCAM_DEPTH=64 -> err pulses at cycle 1, wen stays 0, req_ready is 1 at cycle 2.
REQ-038 TCAM_DEPTH=40, CLEAR_ALL after installs -> two writes, 0x3000 and 0x3001, with wdata 0; a subsequent REMOVE writes 0.
REQ-039 RST_N pulled low at the third key write of an INSTALL -> wen=0 at once; after release, shadow=0 and the next REMOVE writes 0.
